kmeans_k3n5_loader: RTL and testbench
=====================================

KMEANS_K3N5_LOADER -- requirements
Module: kmeans_k3n5_loader

Interface
REQ-001 The block SHALL have parameter data_width, default 8, meaning the width of one dimension value.
REQ-002 The block SHALL have parameter input_data_qty_bit_width, default 8, meaning the width of the memory address and the point counter.
REQ-003 The block SHALL have parameter input_data_qty, default 256, meaning the number of points per load; legal range is 1..2^input_data_qty_bit_width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: begins a load; sampled only in IDLE.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the source presents a point.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the loader accepts a point.
REQ-009 The block SHALL have port in_data, input, 5*data_width bits: d0 in the LSB slice through d4 in the MSB slice.
REQ-010 The block SHALL have port mem_wr_en, output, 1 bit: common write strobe to the five dimension memories.
REQ-011 The block SHALL have port mem_wr_addr, output, input_data_qty_bit_width bits: the write address.
REQ-012 The block SHALL have ports mem_d0_wr_data..mem_d4_wr_data, output, data_width bits each: per-dimension write data.
REQ-013 The block SHALL have port busy, output, 1 bit: high in LOAD.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse at load completion.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD and DONE, and SHALL encode them in registers.
REQ-016 In IDLE, start=1 SHALL move the FSM to LOAD and clear the point counter to 0; otherwise the FSM SHALL stay in IDLE.
REQ-017 in_ready SHALL equal (state==LOAD) and SHALL be combinational from state only, with no dependency on in_valid.
REQ-018 A transfer SHALL occur on a clock edge where in_valid=1 and in_ready=1; no other cycle transfers.
REQ-019 On a transfer, in the next cycle, mem_wr_en SHALL be 1, mem_wr_addr SHALL equal the counter value at the transfer, and mem_dK_wr_data SHALL equal in_data[(K+1)*data_width-1 : K*data_width].
REQ-020 On a transfer, the counter SHALL increment by 1.
REQ-021 mem_wr_en SHALL be 0 in every cycle not following a transfer; the address and data registers SHALL hold their last values when not written.
REQ-022 The write latency SHALL be exactly 1 cycle from transfer to mem_wr_en.
REQ-023 Back-to-back transfers SHALL produce back-to-back writes at consecutive addresses, for a throughput of 1 point per cycle.
REQ-024 A transfer with counter == input_data_qty-1 SHALL be the last; the FSM SHALL go to DONE on that edge, so in_ready is 0 in the following cycle.
REQ-025 When input_data_qty == 2^input_data_qty_bit_width, the counter SHALL wrap to 0 after the last transfer and SHALL NOT cause an extra write.
REQ-026 DONE SHALL last exactly one cycle, with done=1, and then the FSM SHALL go to IDLE.
REQ-027 The final memory write SHALL coincide with the done cycle.
REQ-028 start SHALL be ignored in LOAD and DONE; start held high SHALL re-launch a load in the first IDLE cycle after DONE.
REQ-029 in_valid in IDLE or DONE SHALL be ignored, with no write and no counter change.
REQ-030 With input_data_qty=1, a single transfer SHALL go LOAD->DONE.

Reset
REQ-031 While rst=0 the outputs SHALL be, asynchronously: state=IDLE, counter=0, mem_wr_en=0, mem_wr_addr=0, all mem_dK_wr_data=0, busy=0, done=0, in_ready=0.
REQ-032 Reset during LOAD SHALL abort the load, and a write pending from the last transfer SHALL be dropped.
REQ-033 After rst releases, the block SHALL wait in IDLE for start.

Verification
REQ-034 Bench SHALL cover: reset, start pulse, then 256 back-to-back points, with point i holding dK=(i+K)%256 -> writes at addr 0..255 on consecutive cycles, done is high in the same cycle as the addr-255 write, and in_ready is low thereafter.
REQ-035 Bench SHALL cover: input_data_qty=4, in_valid toggling 1,0,1,1,0,1 -> exactly 4 writes at addr 0,1,2,3, each one cycle after its transfer.
REQ-036 Bench SHALL cover: in_valid=1 with in_data=0x0504030201 while in IDLE, start=0 -> no write, in_ready=0, busy=0.
REQ-037 Bench SHALL cover: rst asserted after 10 transfers, in the cycle after a transfer -> mem_wr_en=0 immediately; a new start then writes from addr 0.
REQ-038 Bench SHALL cover: start held high continuously with input_data_qty=2 -> loads repeat as LOAD,LOAD(transfers),DONE,IDLE,LOAD, and done pulses once per load.
REQ-039 Bench SHALL cover: start pulse in the middle of LOAD -> counter and addresses unaffected.

Source files
------------

// File: rtl/kmeans_k3n5_loader.sv
// Streams five-dimension points into five parallel dimension memories.
// One point per cycle on a valid/ready handshake; done pulses with the final write.
module kmeans_k3n5_loader #(
    parameter int data_width               = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int input_data_qty           = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [5*data_width-1:0]             in_data,
    output logic                                mem_wr_en,
    output logic [input_data_qty_bit_width-1:0] mem_wr_addr,
    output logic [data_width-1:0]               mem_d0_wr_data,
    output logic [data_width-1:0]               mem_d1_wr_data,
    output logic [data_width-1:0]               mem_d2_wr_data,
    output logic [data_width-1:0]               mem_d3_wr_data,
    output logic [data_width-1:0]               mem_d4_wr_data,
    output logic                                busy,
    output logic                                done
);

    localparam int AW = input_data_qty_bit_width;
    localparam logic [AW-1:0] LAST_IDX = AW'(input_data_qty - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [AW-1:0]                   cnt_q, cnt_d;
    logic                            wr_en_q, wr_en_d;
    logic [AW-1:0]                   wr_addr_q, wr_addr_d;
    logic [4:0][data_width-1:0]      wr_data_q, wr_data_d;
    logic                            xfer;

    assign xfer = in_valid && (state_q == ST_LOAD);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = in_data;
                    // wraps to 0 when the load fills the whole address space
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign in_ready       = (state_q == ST_LOAD);
    assign busy           = (state_q == ST_LOAD);
    assign done           = (state_q == ST_DONE);
    assign mem_wr_en      = wr_en_q;
    assign mem_wr_addr    = wr_addr_q;
    assign mem_d0_wr_data = wr_data_q[0];
    assign mem_d1_wr_data = wr_data_q[1];
    assign mem_d2_wr_data = wr_data_q[2];
    assign mem_d3_wr_data = wr_data_q[3];
    assign mem_d4_wr_data = wr_data_q[4];

endmodule

// File: tb/tb_kmeans_k3n5_loader.sv
// Directed bench for kmeans_k3n5_loader: three instances with point counts 256, 4 and 2.
module tb_kmeans_k3n5_loader;

    logic        clk;
    logic        rst;
    logic        start_a, start_b, start_c;
    logic        in_valid;
    logic [39:0] in_data;

    logic       rdy_a, we_a, busy_a, done_a;
    logic [7:0] addr_a, a0, a1, a2, a3, a4;
    logic       rdy_b, we_b, busy_b, done_b;
    logic [7:0] addr_b, b0, b1, b2, b3, b4;
    logic       rdy_c, we_c, busy_c, done_c;
    logic [7:0] addr_c, c0, c1, c2, c3, c4;

    int checks = 0;
    int failures = 0;

    kmeans_k3n5_loader #(.data_width(8), .input_data_qty_bit_width(8), .input_data_qty(256)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .mem_wr_en(we_a), .mem_wr_addr(addr_a),
        .mem_d0_wr_data(a0), .mem_d1_wr_data(a1), .mem_d2_wr_data(a2),
        .mem_d3_wr_data(a3), .mem_d4_wr_data(a4), .busy(busy_a), .done(done_a));

    kmeans_k3n5_loader #(.data_width(8), .input_data_qty_bit_width(8), .input_data_qty(4)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .mem_wr_en(we_b), .mem_wr_addr(addr_b),
        .mem_d0_wr_data(b0), .mem_d1_wr_data(b1), .mem_d2_wr_data(b2),
        .mem_d3_wr_data(b3), .mem_d4_wr_data(b4), .busy(busy_b), .done(done_b));

    kmeans_k3n5_loader #(.data_width(8), .input_data_qty_bit_width(8), .input_data_qty(2)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(in_data), .mem_wr_en(we_c), .mem_wr_addr(addr_c),
        .mem_d0_wr_data(c0), .mem_d1_wr_data(c1), .mem_d2_wr_data(c2),
        .mem_d3_wr_data(c3), .mem_d4_wr_data(c4), .busy(busy_c), .done(done_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // point i carries dK = (i+K) mod 256
    function automatic logic [39:0] pt(input int i);
        logic [39:0] v;
        for (int k = 0; k < 5; k++) v[k*8 +: 8] = 8'(i + k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0] pat_b;
        int         wr_seen;
        int         dones;
        int         ph;

        rst = 1'b1; start_a = 0; start_b = 0; start_c = 0; in_valid = 0; in_data = '0;
        pat_b = 6'b101101;

        // reset values, asynchronously and across clock edges
        #2 rst = 1'b0;
        #1;
        chk("rst_we", 64'(we_a), 64'(0));
        chk("rst_addr", 64'(addr_a), 64'(0));
        chk("rst_data", 64'({a4, a3, a2, a1, a0}), 64'(0));
        chk("rst_ready", 64'(rdy_a), 64'(0));
        chk("rst_busy", 64'(busy_a), 64'(0));
        chk("rst_done", 64'(done_a), 64'(0));
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_ready", 64'({rdy_a, rdy_b, rdy_c}), 64'(0));
        rst = 1'b1;

        // valid in IDLE is ignored
        in_valid = 1'b1; in_data = 40'h0504030201;
        @(negedge clk);
        @(negedge clk);
        chk("idle_we", 64'(we_a), 64'(0));
        chk("idle_ready", 64'(rdy_a), 64'(0));
        chk("idle_busy", 64'(busy_a), 64'(0));
        chk("idle_addr", 64'(addr_a), 64'(0));
        in_valid = 1'b0;

        // 256 back-to-back points, with a stray start pulse mid-load
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; in_valid = 1'b1; in_data = pt(0);
        chk("a_ready_load", 64'(rdy_a), 64'(1));
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            chk("a_we", 64'(we_a), 64'(1));
            chk("a_addr", 64'(addr_a), 64'(i));
            chk("a_data", 64'({a4, a3, a2, a1, a0}), 64'(pt(i)));
            chk("a_done", 64'(done_a), 64'(i == 255));
            chk("a_ready", 64'(rdy_a), 64'(i != 255));
            if (i < 255) in_data = pt(i + 1);
            else in_valid = 1'b0;
            start_a = (i == 99);
        end
        @(negedge clk);
        chk("a_after_we", 64'(we_a), 64'(0));
        chk("a_after_ready", 64'(rdy_a), 64'(0));
        chk("a_after_done", 64'(done_a), 64'(0));
        chk("a_after_addr_hold", 64'(addr_a), 64'(255));

        // qty=4 with gapped valid
        start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        chk("b_ready", 64'(rdy_b), 64'(1));
        wr_seen = 0;
        for (int j = 0; j < 6; j++) begin
            in_valid = pat_b[j]; in_data = pt(50 + j);
            @(negedge clk);
            chk("b_we", 64'(we_b), 64'(pat_b[j]));
            if (we_b) begin
                chk("b_addr", 64'(addr_b), 64'(wr_seen));
                chk("b_data", 64'({b4, b3, b2, b1, b0}), 64'(pt(50 + j)));
                wr_seen++;
            end
            chk("b_done", 64'(done_b), 64'(j == 5));
        end
        in_valid = 1'b1;
        @(negedge clk);
        chk("b_we_in_done", 64'(we_b), 64'(0));
        @(negedge clk);
        chk("b_we_idle", 64'(we_b), 64'(0));
        chk("b_ready_idle", 64'(rdy_b), 64'(0));
        in_valid = 1'b0;
        chk("b_write_count", 64'(wr_seen), 64'(4));

        // qty=2 with start held high: repeating LOAD, LOAD, DONE, IDLE
        start_c = 1'b1; in_valid = 1'b1; in_data = pt(200);
        dones = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            ph = (n - 1) % 4;
            chk("c_busy", 64'(busy_c), 64'(ph < 2));
            chk("c_ready", 64'(rdy_c), 64'(ph < 2));
            chk("c_done", 64'(done_c), 64'(ph == 2));
            chk("c_we", 64'(we_c), 64'(ph == 1 || ph == 2));
            if (ph == 1 || ph == 2) begin
                chk("c_addr", 64'(addr_c), 64'(ph - 1));
                chk("c_data", 64'({c4, c3, c2, c1, c0}), 64'(pt(200)));
            end
            dones += int'(done_c);
        end
        start_c = 1'b0; in_valid = 1'b0;
        chk("c_done_count", 64'(dones), 64'(3));

        // reset after 10 transfers drops the pending write
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = pt(i + 10);
            @(negedge clk);
            chk("r_we", 64'(we_a), 64'(1));
            chk("r_addr", 64'(addr_a), 64'(i));
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("r_abort_we", 64'(we_a), 64'(0));
        chk("r_abort_addr", 64'(addr_a), 64'(0));
        chk("r_abort_ready", 64'(rdy_a), 64'(0));
        chk("r_abort_busy", 64'(busy_a), 64'(0));
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("r_wait_idle", 64'(busy_a), 64'(0));
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; in_valid = 1'b1; in_data = pt(77);
        @(negedge clk);
        chk("r_restart_we", 64'(we_a), 64'(1));
        chk("r_restart_addr", 64'(addr_a), 64'(0));
        chk("r_restart_data", 64'({a4, a3, a2, a1, a0}), 64'(pt(77)));
        in_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
